// File: rtl/prga_decrypt_if.sv
// rtl/prga_decrypt_if.sv - start handshake and S/ct/pt memory ports of the RC4 PRGA stage
// master is the PRGA engine, slave is the controlling FSM plus the three memories.
interface prga_decrypt_if;
  logic       en;
  logic       rdy;
  logic [7:0] s_addr;
  logic [7:0] s_rddata;
  logic [7:0] s_wrdata;
  logic       s_wren;
  logic [7:0] ct_addr;
  logic [7:0] ct_rddata;
  logic [7:0] pt_addr;
  logic [7:0] pt_wrdata;
  logic       pt_wren;
  logic       bad;

  modport master (
    input  en, s_rddata, ct_rddata,
    output rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren, bad
  );

  modport slave (
    output en, s_rddata, ct_rddata,
    input  rdy, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren, bad
  );
endinterface

// File: rtl/prga_decrypt.sv
// rtl/prga_decrypt.sv - RC4 PRGA/decrypt stage: pt[k] = keystream ^ ct[k], pt[0] = ct[0] = length
// Optional PRGA_ASCII_CHECK_EN: flag bad and stop at the first non-printable plaintext byte.
module prga_decrypt (
  input  logic           clk,
  input  logic           rst_n,
  prga_decrypt_if.master bus
);
  typedef enum logic [3:0] {
    ST_IDLE, ST_RD_LEN, ST_GET_LEN, ST_RD_SI, ST_GET_SI, ST_GET_SJ,
    ST_WR_I, ST_WR_J, ST_RD_PAD, ST_GET_PAD, ST_WR_PT, ST_DONE
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [7:0] r_i;
  logic [7:0] r_j;
  logic [7:0] r_k;
  logic [7:0] r_len;
  logic [7:0] r_si;
  logic [7:0] r_sj;
  logic [7:0] r_pad;
  logic [7:0] r_c;
  logic [7:0] w_pt_byte;
  logic       w_accept;
  logic       w_last;
  logic       w_abort;

  assign w_accept  = (r_state == ST_IDLE) && bus.en;
  assign w_pt_byte = r_pad ^ r_c;
  // Compare before incrementing so L=255 terminates even though k wraps afterwards.
  assign w_last    = (r_k == r_len);

`ifdef PRGA_ASCII_CHECK_EN
  logic r_bad;
  assign w_abort = (w_pt_byte < 8'h20) || (w_pt_byte > 8'h7E);
  assign bus.bad = r_bad;
`else
  assign w_abort = 1'b0;
  assign bus.bad = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:    if (bus.en) w_next = ST_RD_LEN;
      ST_RD_LEN:  w_next = ST_GET_LEN;
      ST_GET_LEN: w_next = (bus.ct_rddata == 8'd0) ? ST_DONE : ST_RD_SI;
      ST_RD_SI:   w_next = ST_GET_SI;
      ST_GET_SI:  w_next = ST_GET_SJ;
      ST_GET_SJ:  w_next = ST_WR_I;
      ST_WR_I:    w_next = ST_WR_J;
      ST_WR_J:    w_next = ST_RD_PAD;
      ST_RD_PAD:  w_next = ST_GET_PAD;
      ST_GET_PAD: w_next = ST_WR_PT;
      ST_WR_PT:   w_next = (w_last || w_abort) ? ST_DONE : ST_RD_SI;
      ST_DONE:    w_next = ST_IDLE;
      default:    w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.rdy       = 1'b0;
    bus.s_addr    = 8'd0;
    bus.s_wrdata  = 8'd0;
    bus.s_wren    = 1'b0;
    bus.ct_addr   = 8'd0;
    bus.pt_addr   = 8'd0;
    bus.pt_wrdata = 8'd0;
    bus.pt_wren   = 1'b0;
    case (r_state)
      ST_IDLE:    bus.rdy = 1'b1;
      ST_GET_LEN: begin
        bus.pt_wrdata = bus.ct_rddata;
        bus.pt_wren   = 1'b1;
      end
      ST_RD_SI:   bus.s_addr = r_i + 8'd1;
      ST_GET_SI:  bus.s_addr = r_j + bus.s_rddata;
      ST_WR_I: begin
        bus.s_addr   = r_i;
        bus.s_wrdata = r_sj;
        bus.s_wren   = 1'b1;
      end
      ST_WR_J: begin
        bus.s_addr   = r_j;
        bus.s_wrdata = r_si;
        bus.s_wren   = 1'b1;
      end
      ST_RD_PAD: begin
        bus.s_addr  = r_si + r_sj;
        bus.ct_addr = r_k;
      end
      ST_WR_PT: begin
        bus.pt_addr   = r_k;
        bus.pt_wrdata = w_pt_byte;
        bus.pt_wren   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_i   <= 8'd0;
      r_j   <= 8'd0;
      r_k   <= 8'd0;
      r_len <= 8'd0;
      r_si  <= 8'd0;
      r_sj  <= 8'd0;
      r_pad <= 8'd0;
      r_c   <= 8'd0;
`ifdef PRGA_ASCII_CHECK_EN
      r_bad <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_i <= 8'd0;
          r_j <= 8'd0;
          r_k <= 8'd1;
`ifdef PRGA_ASCII_CHECK_EN
          r_bad <= 1'b0;
`endif
        end
        ST_GET_LEN: r_len <= bus.ct_rddata;
        ST_RD_SI:   r_i   <= r_i + 8'd1;
        ST_GET_SI: begin
          r_si <= bus.s_rddata;
          r_j  <= r_j + bus.s_rddata;
        end
        ST_GET_SJ:  r_sj <= bus.s_rddata;
        ST_GET_PAD: begin
          r_pad <= bus.s_rddata;
          r_c   <= bus.ct_rddata;
        end
        ST_WR_PT: begin
          r_k <= r_k + 8'd1;
`ifdef PRGA_ASCII_CHECK_EN
          if (w_abort) r_bad <= 1'b1;
`endif
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_prga_decrypt.sv
// tb/tb_prga_decrypt.sv - randomized scoreboard bench for prga_decrypt against an RC4 reference model
`timescale 1ns/1ps
module tb_prga_decrypt;
  logic clk = 1'b0;
  logic rst_n;
  logic load;

  prga_decrypt_if bus();
  prga_decrypt dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;

  logic [7:0]  s_img  [256];
  logic [7:0]  ct_img [256];
  logic [7:0]  s_mem  [256];
  logic [7:0]  pt_mem [256];
  int          ref_s  [256];
  logic [15:0] exp_q  [$];
  int n_total, n_pass, n_ptw, n_sw;

  // Synchronous memories with one-cycle read latency
  always @(posedge clk) begin
    bus.s_rddata  <= s_mem[bus.s_addr];
    bus.ct_rddata <= ct_img[bus.ct_addr];
    if (load) begin
      for (int n = 0; n < 256; n++) begin
        s_mem[n]  <= s_img[n];
        pt_mem[n] <= 8'h00;
      end
    end else begin
      if (bus.s_wren)  s_mem[bus.s_addr]   <= bus.s_wrdata;
      if (bus.pt_wren) pt_mem[bus.pt_addr] <= bus.pt_wrdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic monitor();
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (bus.s_wren) n_sw++;
      if (bus.s_wren || bus.pt_wren)
        check("wren_exclusive_busy", {30'd0, bus.s_wren && bus.pt_wren, bus.rdy}, 32'd0);
      if (bus.pt_wren) begin
        n_ptw++;
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL pt_unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                   bus.pt_addr, bus.pt_wrdata);
        end else begin
          e = exp_q.pop_front();
          check("pt_write", {16'd0, bus.pt_addr, bus.pt_wrdata}, {16'd0, e});
        end
      end
    end
  endtask

  // RC4 PRGA on ref_s; pushes every expected plaintext write
  task automatic model_run(output int nproc, output bit xbad);
    int i, j, t, p, len;
    len   = int'(ct_img[0]);
    nproc = 0;
    xbad  = 1'b0;
    i = 0;
    j = 0;
    exp_q.push_back({8'd0, ct_img[0]});
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + ref_s[i]) % 256;
      t = ref_s[i]; ref_s[i] = ref_s[j]; ref_s[j] = t;
      p = ref_s[(ref_s[i] + ref_s[j]) % 256] ^ int'(ct_img[k]);
      exp_q.push_back({k[7:0], p[7:0]});
      nproc++;
`ifdef PRGA_ASCII_CHECK_EN
      if (p < 32 || p > 126) begin
        xbad = 1'b1;
        break;
      end
`endif
    end
  endtask

  task automatic shuffle_s();
    int m;
    logic [7:0] t;
    for (int n = 0; n < 256; n++) s_img[n] = n[7:0];
    for (int n = 255; n > 0; n--) begin
      m = $urandom_range(0, n);
      t = s_img[n]; s_img[n] = s_img[m]; s_img[m] = t;
    end
  endtask

  task automatic random_ct(input int len);
    ct_img[0] = len[7:0];
    for (int n = 1; n < 256; n++) ct_img[n] = 8'($urandom_range(0, 255));
  endtask

  // Ciphertext whose first-run plaintext is printable, so runs are never cut short
  task automatic ascii_ct(input int len);
    int s [256];
    int i, j, t, p, c;
    for (int n = 0; n < 256; n++) s[n] = int'(s_img[n]);
    random_ct(len);
    i = 0;
    j = 0;
    for (int k = 1; k <= len; k++) begin
      i = (i + 1) % 256;
      j = (j + s[i]) % 256;
      t = s[i]; s[i] = s[j]; s[j] = t;
      p = s[(s[i] + s[j]) % 256];
      c = $urandom_range(32, 126);
      ct_img[k] = p[7:0] ^ c[7:0];
    end
  endtask

  task automatic load_mem();
    for (int n = 0; n < 256; n++) ref_s[n] = int'(s_img[n]);
    @(negedge clk); load = 1'b1;
    @(negedge clk); load = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk); bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk); bus.en = 1'b0;
  endtask

  task automatic wait_rdy(input int budget, output int n);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      @(negedge clk);
    end while (!bus.rdy && n < budget);
  endtask

  task automatic check_s(input string tag);
    int mism;
    mism = 0;
    for (int n = 0; n < 256; n++) if ({24'd0, s_mem[n]} != ref_s[n]) mism++;
    check({tag, "_s_final_mismatches"}, mism, 0);
  endtask

  task automatic run_check(input string tag, input int mid_en);
    int nproc, lat, extra, sw0;
    bit xbad;
    model_run(nproc, xbad);
    sw0   = n_sw;
    extra = 0;
    start_pulse();
    if (mid_en > 0) begin
      repeat (mid_en) @(negedge clk);
      bus.en = 1'b1;
      @(negedge clk);
      bus.en = 1'b0;
      extra = mid_en + 1;
    end
    wait_rdy(4000, lat);
    check({tag, "_latency"}, lat + extra, 3 + 8 * nproc);
    check({tag, "_bad"}, {31'd0, bus.bad}, {31'd0, xbad});
    check({tag, "_s_writes"}, n_sw - sw0, 2 * nproc);
    check({tag, "_pt_pending"}, exp_q.size(), 0);
    check_s(tag);
  endtask

  initial begin
    int n1, n2, lat, sw0, p0, cyc;
    bit b1, b2;
    n_total = 0; n_pass = 0; n_ptw = 0; n_sw = 0;
    bus.en = 1'b0; load = 1'b0; rst_n = 1'b0;
    for (int n = 0; n < 256; n++) begin
      s_img[n]  = n[7:0];
      ct_img[n] = 8'h00;
    end
    fork
      monitor();
    join_none

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdy", {31'd0, bus.rdy}, 32'd1);
    check("reset_s_wren", {31'd0, bus.s_wren}, 32'd0);
    check("reset_pt_wren", {31'd0, bus.pt_wren}, 32'd0);
    check("reset_bad", {31'd0, bus.bad}, 32'd0);
    check("reset_addrs", {8'd0, bus.s_addr, bus.ct_addr, bus.pt_addr}, 32'd0);
    check("reset_wrdata", {16'd0, bus.s_wrdata, bus.pt_wrdata}, 32'd0);
    rst_n = 1'b1;

    // Identity S, ct = {03,00,00,00}
    ct_img[0] = 8'h03;
    load_mem();
    run_check("identity", 0);
`ifdef PRGA_ASCII_CHECK_EN
    check("identity_bad_set", {31'd0, bus.bad}, 32'd1);
    check("identity_pt1", pt_mem[1], 8'h02);
    check("identity_pt2_unwritten", pt_mem[2], 8'h00);
`else
    check("identity_pt", {pt_mem[0], pt_mem[1], pt_mem[2], pt_mem[3]}, 32'h03020507);
    check("identity_s235", {8'd0, s_mem[2], s_mem[3], s_mem[5]}, 32'h00030502);
`endif

    // Zero-length message
    shuffle_s();
    random_ct(0);
    load_mem();
    run_check("len0", 0);

    // Randomized permutations and messages, including maximum length
    for (int r = 0; r < 6; r++) begin
      shuffle_s();
      if (r == 0)      ascii_ct(255);
      else if (r < 3)  ascii_ct($urandom_range(1, 24));
      else             random_ct($urandom_range(1, 24));
      load_mem();
      run_check(r == 0 ? "rand_len255" : "rand", r == 2 ? 5 : 0);
    end

    // en held high: exactly one run per IDLE visit
    shuffle_s();
    ascii_ct(4);
    load_mem();
    model_run(n1, b1);
    model_run(n2, b2);
    sw0 = n_sw;
    @(negedge clk); bus.en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    wait_rdy(4000, lat);
    check("held_run1_latency", lat, 3 + 8 * n1);
    @(negedge clk);
    check("held_reaccept", {31'd0, bus.rdy}, 32'd0);
    bus.en = 1'b0;
    wait_rdy(4000, lat);
    check("held_run2_latency", lat, 3 + 8 * n2);
    check("held_s_writes", n_sw - sw0, 2 * (n1 + n2));
    check("held_pt_pending", exp_q.size(), 0);
    check_s("held");
    repeat (5) @(negedge clk);
    check("held_no_third_run", {31'd0, bus.rdy}, 32'd1);

    // Reset during byte 2, then rerun from the same S snapshot
    shuffle_s();
    ascii_ct(6);
    load_mem();
    model_run(n1, b1);
    p0 = n_ptw;
    start_pulse();
    cyc = 0;
    while ((n_ptw - p0) < 2 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_reached_byte2", {31'd0, (n_ptw - p0) >= 2}, 32'd1);
    repeat (3) @(negedge clk);
    exp_q.delete();
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("midrst_rdy", {31'd0, bus.rdy}, 32'd1);
    check("midrst_wren", {30'd0, bus.s_wren, bus.pt_wren}, 32'd0);
    check("midrst_bad", {31'd0, bus.bad}, 32'd0);
    rst_n = 1'b1;
    load_mem();
    run_check("rst_rerun", 0);

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/prga_decrypt.md
Name: prga_decrypt

Overview:
- RC4 pseudo-random generation and decrypt stage; sits directly downstream of the KSA stage inside task3.
- Consumes the KSA-scrambled S memory and the length-prefixed ciphertext memory (ct[0] = length L).
- XORs each ciphertext byte with the keystream and writes the length-prefixed plaintext memory.
- Uses the same en/rdy start handshake as the init and KSA stages; the top-level FSM starts it once KSA reports rdy.

Parameters:
- None. Byte width 8, S size 256 and memory depth 256 are fixed by RC4.

Ports:
- clk  in  1  system clock, CLOCK_50 at top level
- rst_n  in  1  synchronous active-low reset
- en  in  1  start request; accepted only when rdy=1
- rdy  out  1  idle / ready for a new request
- s_addr  out  8  S memory address
- s_rddata  in  8  S read data, valid the cycle after s_addr is presented
- s_wrdata  out  8  S write data
- s_wren  out  1  S write enable
- ct_addr  out  8  ciphertext address
- ct_rddata  in  8  ciphertext read data, 1-cycle latency
- pt_addr  out  8  plaintext address
- pt_wrdata  out  8  plaintext write data
- pt_wren  out  1  plaintext write enable
- bad  out  1  plaintext check flag; see Optional Feature

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - Next state IDLE; rdy=1.
  - s_wren=0, pt_wren=0, bad=0.
  - All address/data outputs and internal i, j, k, L registers = 0.
- Reset mid-operation: abandon the run, no further writes; memory contents left as-is.
- Handshake:
  - Start is accepted on the edge where en=1 and rdy=1. rdy drops on that edge.
  - en while busy is ignored.
  - rdy rises only on return to IDLE.
- States, one cycle each unless noted:
  - IDLE: rdy=1. On accept: i=0, j=0, k=1, drive ct_addr=0, go to RD_LEN.
  - RD_LEN: wait for read latency.
  - GET_LEN: L=ct_rddata; write pt[0]=L (pt_wren=1). If L=0 go to DONE, else RD_SI.
  - RD_SI: i=i+1 (mod 256); s_addr=i+1.
  - GET_SI: si=s_rddata; j=j+si (mod 256); s_addr=new j.
  - GET_SJ: sj=s_rddata.
  - WR_I: s[i]=sj.
  - WR_J: s[j]=si.
  - RD_PAD: s_addr=(si+sj) mod 256; ct_addr=k.
  - GET_PAD: latch pad=s_rddata and c=ct_rddata.
  - WR_PT: pt[k]=pad^c; k=k+1. If old k==L go to DONE, else RD_SI.
  - DONE: write enables low; go to IDLE.
- Per-byte cost is exactly 8 cycles (RD_SI..WR_PT).
- Latency: rdy returns high 3+8L cycles after the accept edge (L=0 gives 3).
- Arithmetic: all index arithmetic wraps mod 256 with 8-bit truncation.
- Processes bytes 1..L inclusive; L=255 is the maximum and k must not overflow before compare.
- i==j case: WR_I then WR_J write the same address, leaving s[i] unchanged, as RC4 requires.
- At most one write enable asserted per cycle; wren is never asserted in IDLE.

Optional Feature:
- Macro: PRGA_ASCII_CHECK_EN.
- Defined:
  - In WR_PT, if pad^c is outside 0x20..0x7E, set bad=1, still perform that write, then go to DONE (early abort, remaining bytes not written).
  - bad holds until the next accepted start or reset. Used by the key-crack stage.
- Undefined: bad is tied to 0 and no early abort occurs.

Test Plan:
- Identity S (s[n]=n), ct={03,00,00,00}, pulse en -> pt={03,02,05,07}; rdy high exactly 27 cycles after accept; final s[2]=03, s[3]=05, s[5]=02.
- ct[0]=00 -> only pt[0]=00 written, no S writes, rdy back after 3 cycles.
- Full chain init+KSA+PRGA, key 0x000018, test2.memh ciphertext -> pt matches software RC4 model for all bytes 0..L.
- Assert rst_n=0 for one cycle during byte 2 -> next cycle rdy=1, no wren; restart with same S snapshot reloaded gives correct output.
- en held high continuously -> exactly one run per IDLE visit; en pulsed mid-run is ignored.
- With PRGA_ASCII_CHECK_EN, identity S and ct={03,00,00,00} -> bad=1 after byte 1 (0x02), only pt[0..1] written; without the macro -> bad stays 0 and the full output is written.
